// File: rtl/cart_mem_bridge_if.sv
//------------------------------------------------------------------------------
// Module  : cart_mem_bridge_if
// Brief   : MBC-side strobes and SDRAM req/ack bus seen by cart_mem_bridge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cart_mem_bridge_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mbc_addr;
    logic              mbc_rd;
    logic              mbc_wr;
    logic [DATA_W-1:0] mbc_wdata;
    logic [DATA_W-1:0] mbc_rdata;
    logic              mbc_wait;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              err_timeout;

    // The bridge itself
    modport slave (
        input  mbc_addr, mbc_rd, mbc_wr, mbc_wdata, mem_ack, mem_rdata,
        output mbc_rdata, mbc_wait, mem_req, mem_we, mem_addr, mem_wdata, err_timeout
    );

    // The surrounding MBC and SDRAM controller
    modport master (
        output mbc_addr, mbc_rd, mbc_wr, mbc_wdata, mem_ack, mem_rdata,
        input  mbc_rdata, mbc_wait, mem_req, mem_we, mem_addr, mem_wdata, err_timeout
    );
endinterface

`default_nettype wire

// File: rtl/cart_mem_bridge.sv
//------------------------------------------------------------------------------
// Module  : cart_mem_bridge
// Brief   : One req/ack transaction per MBC access, with a one-byte read cache.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cart_mem_bridge #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  wire logic        clk,
    input  wire logic        reset,
    cart_mem_bridge_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_timeout_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cache_valid_q;
    logic [ADDR_W-1:0] cache_addr_q;
    logic [DATA_W-1:0] cache_data_q;
    logic [ADDR_W-1:0] tag_addr_q;
    logic              tag_we_q;

    logic access;
    logic hit;
    logic tag_same;
    logic wait_c;

    assign access   = bus.mbc_rd | bus.mbc_wr;
    // mbc_wr wins over mbc_rd, so only a pure read can hit
    assign hit      = bus.mbc_rd & ~bus.mbc_wr & cache_valid_q &
                      (bus.mbc_addr == cache_addr_q);
    assign tag_same = (bus.mbc_addr == tag_addr_q) && (bus.mbc_wr == tag_we_q);

    always_comb begin
        wait_c = 1'b0;
        case (state_q)
            S_REQ:   wait_c = ~bus.mem_ack;
            S_IDLE:  wait_c = access & ~hit;
            S_HOLD:  wait_c = access & ~tag_same;
            default: wait_c = 1'b0;
        endcase
    end

    assign bus.mbc_wait    = wait_c;
    assign bus.mbc_rdata   = rdata_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.err_timeout = err_timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= {DATA_W{1'b1}};
            err_timeout_q <= 1'b0;
            cnt_q         <= '0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
            tag_addr_q    <= '0;
            tag_we_q      <= 1'b0;
        end else begin
            err_timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (access) begin
                        tag_addr_q <= bus.mbc_addr;
                        tag_we_q   <= bus.mbc_wr;
                        if (hit) begin
                            rdata_q <= cache_data_q;
                            state_q <= S_HOLD;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.mbc_wr;
                            mem_addr_q  <= bus.mbc_addr;
                            mem_wdata_q <= bus.mbc_wdata;
                            cnt_q       <= '0;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    // An ack in the final cycle still counts as completion
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_HOLD;
                        if (!mem_we_q) begin
                            rdata_q       <= bus.mem_rdata;
                            cache_data_q  <= bus.mem_rdata;
                            cache_addr_q  <= mem_addr_q;
                            cache_valid_q <= 1'b1;
                        end else if (mem_addr_q == cache_addr_q) begin
                            cache_data_q <= mem_wdata_q;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q     <= 1'b0;
                        rdata_q       <= {DATA_W{1'b1}};
                        err_timeout_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!access || !tag_same) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_cart_mem_bridge.sv
//------------------------------------------------------------------------------
// Module  : tb_cart_mem_bridge
// Brief   : Vector table plus request/read-data scoreboards for cart_mem_bridge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cart_mem_bridge;
    localparam int ADDR_W      = 26;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 64;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                hold;
        logic              exp_req;
        int                exp_wait;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cart_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    cart_mem_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    int checks = 0;
    int errors = 0;
    req_t              req_q[$];
    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] sdram[logic [ADDR_W-1:0]];

    int   req_count = 0;
    int   req_hi    = 0;
    int   err_hi    = 0;
    logic req_prev  = 1'b0;

    logic ack_en     = 1'b1;
    int   ack_delay  = 3;
    int   req_cyc    = 0;
    logic inject_ack = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] sd_read(input logic [ADDR_W-1:0] a);
        return sdram.exists(a) ? sdram[a] : (a[7:0] ^ 8'h5A);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SDRAM controller model: ack ack_delay cycles after the first req cycle
    always @(posedge clk) begin
        logic ack_n;
        #1;
        ack_n = 1'b0;
        if (ack_en && ifc.mem_req) begin
            if (req_cyc == ack_delay) begin
                ack_n   = 1'b1;
                req_cyc = 0;
            end else begin
                req_cyc++;
            end
        end else if (!ifc.mem_req) begin
            req_cyc = 0;
        end
        ifc.mem_rdata = (ack_n && !ifc.mem_we) ? sd_read(ifc.mem_addr) : 8'h99;
        if (ack_n && ifc.mem_we) sdram[ifc.mem_addr] = ifc.mem_wdata;
        ifc.mem_ack = ack_n | inject_ack;
    end

    // Request scoreboard: every rising mem_req must match the oldest expected request
    always @(negedge clk) begin
        req_t exp;
        if (ifc.mem_req) req_hi++;
        if (ifc.err_timeout) err_hi++;
        if (ifc.mem_req && !req_prev) begin
            req_count++;
            if (req_q.size() == 0) begin
                check("unexpected_req", {ifc.mem_we, ifc.mem_addr, ifc.mem_wdata}, 64'h0);
            end else begin
                exp = req_q.pop_front();
                check("req_fields", {ifc.mem_we, ifc.mem_addr, ifc.mem_wdata}, exp);
            end
        end
        req_prev = ifc.mem_req;
    end

    task automatic run_vec(input vec_t v, input string tag);
        int wc;
        int hold_wait;
        int req0;
        req0 = req_count;
        if (v.exp_req) req_q.push_back({v.wr, v.addr, v.wdata});
        if (!v.wr) rd_q.push_back(v.exp_rdata);
        ifc.mbc_rd    = v.rd;
        ifc.mbc_wr    = v.wr;
        ifc.mbc_addr  = v.addr;
        ifc.mbc_wdata = v.wdata;
        wc = 0;
        #2;
        while (ifc.mbc_wait && wc < 200) begin
            wc++;
            step();
            #2;
        end
        check({tag, "_wait_cycles"}, 64'(wc), 64'(v.exp_wait));
        step();
        #2;
        if (!v.wr) check({tag, "_rdata"}, 64'(ifc.mbc_rdata), 64'(rd_q.pop_front()));
        hold_wait = 0;
        repeat (v.hold) begin
            step();
            #2;
            if (ifc.mbc_wait) hold_wait++;
        end
        check({tag, "_hold_wait"}, 64'(hold_wait), 64'h0);
        ifc.mbc_rd = 1'b0;
        ifc.mbc_wr = 1'b0;
        step();
        check({tag, "_req_count"}, 64'(req_count - req0), 64'(v.exp_req));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   e0;
        int   h0;
        int   wc;
        vec_t v;

        ifc.mbc_rd = 1'b0; ifc.mbc_wr = 1'b0; ifc.mbc_addr = '0; ifc.mbc_wdata = '0;
        sdram[26'h0004000] = 8'h3C;

        //           rd    wr    addr          wdata  hold req  wait rdata
        vecs[0] = '{1'b1, 1'b0, 26'h0004000, 8'h00, 20, 1'b1, 4, 8'h3C};
        vecs[1] = '{1'b1, 1'b0, 26'h0004000, 8'h00,  0, 1'b0, 0, 8'h3C};
        vecs[2] = '{1'b0, 1'b1, 26'h2000100, 8'h55, 10, 1'b1, 4, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 26'h2000100, 8'h00,  2, 1'b1, 4, 8'h55};
        vecs[4] = '{1'b1, 1'b0, 26'h0004000, 8'h00,  0, 1'b1, 4, 8'h3C};
        vecs[5] = '{1'b0, 1'b1, 26'h0004000, 8'hAA,  3, 1'b1, 4, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 26'h0004000, 8'h00,  3, 1'b0, 0, 8'hAA};
        vecs[7] = '{1'b1, 1'b0, 26'h0000123, 8'h00,  0, 1'b1, 4, 8'h79};
        vecs[8] = '{1'b1, 1'b1, 26'h0000123, 8'h11,  2, 1'b1, 4, 8'h00};
        vecs[9] = '{1'b1, 1'b0, 26'h0000123, 8'h00,  1, 1'b0, 0, 8'h11};

        repeat (3) step();
        #2;
        check("rst_mem_req",   64'(ifc.mem_req),     64'h0);
        check("rst_mem_we",    64'(ifc.mem_we),      64'h0);
        check("rst_mem_addr",  64'(ifc.mem_addr),    64'h0);
        check("rst_mem_wdata", 64'(ifc.mem_wdata),   64'h0);
        check("rst_rdata",     64'(ifc.mbc_rdata),   64'hFF);
        check("rst_wait",      64'(ifc.mbc_wait),    64'h0);
        check("rst_err",       64'(ifc.err_timeout), 64'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Timeout: no ack ever arrives; cache (0x0000123 = 0x11) must survive
        ack_en = 1'b0;
        e0 = err_hi;
        h0 = req_hi;
        req_q.push_back({1'b0, 26'h0300000, 8'h00});
        ifc.mbc_rd = 1'b1; ifc.mbc_addr = 26'h0300000; ifc.mbc_wdata = 8'h00;
        wc = 0;
        #2;
        while (ifc.mbc_wait && wc < 200) begin
            wc++;
            step();
            #2;
        end
        check("to_wait_cycles", 64'(wc),            64'(TIMEOUT_CYC + 1));
        check("to_rdata",       64'(ifc.mbc_rdata), 64'hFF);
        check("to_mem_req",     64'(ifc.mem_req),   64'h0);
        step();
        #2;
        check("to_hold_wait",   64'(ifc.mbc_wait),  64'h0);
        ifc.mbc_rd = 1'b0;
        step();
        check("to_err_pulses",  64'(err_hi - e0),   64'h1);
        check("to_req_cycles",  64'(req_hi - h0),   64'(TIMEOUT_CYC));
        ack_en = 1'b1;
        v = '{1'b1, 1'b0, 26'h0000123, 8'h00, 0, 1'b0, 0, 8'h11};
        run_vec(v, "to_cache_kept");

        // Reset two cycles into REQ, then a stray ack that must be ignored
        ack_delay = 5;
        e0 = err_hi;
        req_q.push_back({1'b0, 26'h0004000, 8'h00});
        ifc.mbc_rd = 1'b1; ifc.mbc_addr = 26'h0004000;
        step();
        step();
        #2;
        check("rr_in_req", 64'(ifc.mem_req), 64'h1);
        reset = 1'b1;
        ifc.mbc_rd = 1'b0;
        step();
        #2;
        check("rr_mem_req", 64'(ifc.mem_req),   64'h0);
        check("rr_wait",    64'(ifc.mbc_wait),  64'h0);
        check("rr_rdata",   64'(ifc.mbc_rdata), 64'hFF);
        reset = 1'b0;
        inject_ack = 1'b1;
        step();
        #1;
        inject_ack = 1'b0;
        step();
        #2;
        check("rr_late_req",   64'(ifc.mem_req),   64'h0);
        check("rr_late_wait",  64'(ifc.mbc_wait),  64'h0);
        check("rr_late_rdata", 64'(ifc.mbc_rdata), 64'hFF);
        check("rr_no_err",     64'(err_hi - e0),   64'h0);
        step();
        ack_delay = 3;
        v = '{1'b1, 1'b0, 26'h0000123, 8'h00, 0, 1'b1, 4, 8'h11};
        run_vec(v, "rr_cache_invalid");

        check("req_queue_empty", 64'(req_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
